fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  meaning synchronous, active-high reset.
REQ-004 SHALL have port stall  input  1  meaning the hazard-unit load-use stall: hold the PC and the IF/ID register.
REQ-005 SHALL have port and_z_b  input  1  meaning the branch taken in ID.
REQ-006 SHALL have port branch_adder  input  32  meaning the branch target from ID.
REQ-007 SHALL have port Jmp  input  2  meaning the jump select: 00 none, 01 immediate jump, 10 register jump, 11 treated as 00.
REQ-008 SHALL have port jmp_addr  input  26  meaning the immediate jump field from ID.
REQ-009 SHALL have port address_on_reg  input  32  meaning the JR/JALR target from ID.
REQ-010 SHALL have port id_pc4  input  32  meaning the PC+4 of the instruction currently in ID.
REQ-011 SHALL have port out_pc  output  32  meaning the fetch address to instruction memory (registered).
REQ-012 SHALL have port pc2id  output  32  meaning out_pc+4, passed to IF/ID.
REQ-013 SHALL have port ifid_write  output  1  meaning the IF/ID register load enable.
REQ-014 SHALL have port ifid_flush  output  1  meaning insert a bubble into IF/ID at this edge.
REQ-015 SHALL have port state  output  2  meaning the FSM state: 00 BOOT, 01 RUN, 10 STALL, 11 REDIRECT.
REQ-016 SHALL have port stall_count  output  16  meaning the number of stalled cycles, saturating.
REQ-017 SHALL have port redirect_count  output  16  meaning the number of taken redirects, saturating.
REQ-018 SHALL have port misalign  output  1  meaning sticky: a register-jump target had a nonzero address_on_reg[1:0].

Function
REQ-019 SHALL compute pc_plus4 = out_pc + 4 modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0.
REQ-020 SHALL assign pc2id = pc_plus4 combinationally.
REQ-021 SHALL define redirect = (Jmp==01) | (Jmp==10) | (Jmp!=01 & Jmp!=10 & and_z_b).
REQ-022 SHALL select the target by priority: Jmp==01 -> {id_pc4[31:28], jmp_addr, 2'b00}; Jmp==10 -> {address_on_reg[31:2], 2'b00}; else and_z_b -> branch_adder; else pc_plus4.
REQ-023 SHALL give stall priority over redirect: while stall=1, hold out_pc, ifid_write=0, ifid_flush=0, and ignore redirect.
REQ-024 In BOOT, SHALL hold out_pc, assert ifid_flush=1 and ifid_write=0, and go to RUN next cycle regardless of the other inputs.
REQ-025 In RUN or STALL with stall=1: SHALL go to STALL and increment stall_count unless it equals 16'hFFFF.
REQ-026 In RUN or STALL with stall=0 and redirect=1: SHALL load out_pc with the target, assert ifid_flush=1 and ifid_write=1, increment redirect_count (saturating), and go to REDIRECT.
REQ-027 In RUN or STALL with stall=0 and redirect=0: SHALL load out_pc with pc_plus4, assert ifid_write=1 and ifid_flush=0, and go to RUN.
REQ-028 In REDIRECT: ID holds a bubble, so the block SHALL ignore redirect, load pc_plus4 (or hold if stall=1, entering STALL), and otherwise go to RUN.
REQ-029 SHALL set misalign when a Jmp==10 redirect is taken with address_on_reg[1:0]!=00; it clears only on rst.
REQ-030 SHALL drive ifid_write and ifid_flush combinationally from state and inputs; out_pc, state, the counters and misalign are registered.
REQ-031 SHALL never assert ifid_flush and a stall hold in the same cycle.

Reset
REQ-032 On a rising edge with rst=1: out_pc=RESET_PC, state=BOOT, stall_count=0, redirect_count=0, misalign=0; while rst=1, ifid_write=0 and ifid_flush=1.
REQ-033 Reset SHALL override stall, redirect and any mid-operation state (STALL or REDIRECT) in the same edge.

Verification
REQ-034 Release rst, no stall or redirect -> BOOT for 1 cycle with out_pc=0, then out_pc=0,4,8,12 on consecutive cycles; ifid_flush=1 only in BOOT.
REQ-035 In RUN at out_pc=0x40, stall high for 3 cycles -> out_pc stays 0x40, ifid_write=0, stall_count=3, state=STALL; at release -> out_pc=0x44.
REQ-036 and_z_b=1, branch_adder=0x100 -> next out_pc=0x100, ifid_flush=1, state=REDIRECT, redirect_count=1; a branch asserted in REDIRECT is ignored (out_pc=0x104).
REQ-037 Jmp=01, id_pc4=0x9000_0010, jmp_addr=26'h10 -> out_pc=0x9000_0040; Jmp=10 with address_on_reg=0x203 -> out_pc=0x200 and misalign=1 (sticky).
REQ-038 stall=1 with Jmp=10 at the same time -> PC held with no flush; the next cycle with stall=0 and Jmp=10 -> redirect taken.
REQ-039 Preload the counters to 16'hFFFF via a long stall or redirect run -> they hold at 16'hFFFF; out_pc=0xFFFF_FFFC free-running -> wraps to 0; rst asserted in STALL -> BOOT with counters at 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Purpose:
//   This block is the instruction-fetch front end of the pipeline. It holds
//   the fetch PC and decides each cycle where the next fetch goes: either
//   sequentially to PC+4, or to a branch or jump target supplied by ID. It
//   also drives the IF/ID load enable and the IF/ID bubble (flush), and it
//   keeps two saturating event counters and a sticky misalignment flag.
//
// Parameters:
//   RESET_PC        PC value loaded on reset.
//
// Ports:
//   clk             single clock; all state updates on its rising edge
//   rst             synchronous, active-high reset
//   stall           load-use stall from the hazard unit; holds the PC and IF/ID
//   and_z_b         a branch is taken in ID
//   branch_adder    branch target computed in ID
//   Jmp             jump select: 00 none, 01 immediate, 10 register, 11 none
//   jmp_addr        26-bit immediate jump field from ID
//   address_on_reg  JR/JALR target register value from ID
//   id_pc4          PC+4 of the instruction currently in ID
//   out_pc          registered fetch address to instruction memory
//   pc2id           out_pc+4, forwarded to IF/ID
//   ifid_write      IF/ID load enable
//   ifid_flush      insert a bubble into IF/ID at this edge
//   state           FSM state: 00 BOOT, 01 RUN, 10 STALL, 11 REDIRECT
//   stall_count     saturating count of stalled cycles
//   redirect_count  saturating count of taken redirects
//   misalign        sticky flag: a register jump had nonzero target bits [1:0]
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        and_z_b,
  input  logic [31:0] branch_adder,
  input  logic [1:0]  Jmp,
  input  logic [25:0] jmp_addr,
  input  logic [31:0] address_on_reg,
  input  logic [31:0] id_pc4,
  output logic [31:0] out_pc,
  output logic [31:0] pc2id,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic [1:0]  state,
  output logic [15:0] stall_count,
  output logic [15:0] redirect_count,
  output logic        misalign
);

  typedef enum logic [1:0] {
    BOOT     = 2'b00,
    RUN      = 2'b01,
    STALL    = 2'b10,
    REDIRECT = 2'b11
  } state_t;

  localparam logic [1:0]  JMP_IMM = 2'b01;
  localparam logic [1:0]  JMP_REG = 2'b10;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_out_pc;
  logic [31:0] w_next_pc;
  logic [15:0] r_stall_count;
  logic [15:0] r_redirect_count;
  logic        r_misalign;

  logic [31:0] w_pc_plus4;
  logic        w_jmp_imm;
  logic        w_jmp_reg;
  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_stall_inc;
  logic        w_redirect_inc;
  logic        w_set_misalign;

  // Sequential fetch address; the 32-bit add wraps naturally at the top of
  // the address space.
  assign w_pc_plus4 = r_out_pc + 32'd4;
  assign pc2id      = w_pc_plus4;

  // Jmp==11 is decoded as "no jump", so only the two explicit encodings
  // count as jumps and a branch is only considered when neither is present.
  assign w_jmp_imm  = (Jmp == JMP_IMM);
  assign w_jmp_reg  = (Jmp == JMP_REG);
  assign w_redirect = w_jmp_imm | w_jmp_reg | (~w_jmp_imm & ~w_jmp_reg & and_z_b);

  // Target priority: immediate jump, then register jump (word-aligned by
  // dropping the low two bits), then branch, then fall-through.
  always_comb begin
    w_target = w_pc_plus4;
    if (w_jmp_imm) begin
      w_target = {id_pc4[31:28], jmp_addr, 2'b00};
    end else if (w_jmp_reg) begin
      w_target = {address_on_reg[31:2], 2'b00};
    end else if (and_z_b) begin
      w_target = branch_adder;
    end
  end

  // Next-state and IF/ID control. A stall always wins over a redirect, so a
  // held cycle never flushes. The REDIRECT state exists because ID carries
  // the bubble inserted by the previous flush, so anything ID presents as a
  // branch or jump in that cycle is stale and must not redirect again.
  // Reset forces the IF/ID controls to "flush, no write" for as long as it
  // is held, independent of the state decode.
  always_comb begin
    w_next_state   = r_state;
    w_next_pc      = r_out_pc;
    ifid_write     = 1'b0;
    ifid_flush     = 1'b0;
    w_stall_inc    = 1'b0;
    w_redirect_inc = 1'b0;
    w_set_misalign = 1'b0;

    case (r_state)
      BOOT: begin
        ifid_flush   = 1'b1;
        w_next_state = RUN;
      end

      RUN, STALL: begin
        if (stall) begin
          w_stall_inc  = 1'b1;
          w_next_state = STALL;
        end else if (w_redirect) begin
          w_next_pc      = w_target;
          ifid_write     = 1'b1;
          ifid_flush     = 1'b1;
          w_redirect_inc = 1'b1;
          w_set_misalign = w_jmp_reg & (address_on_reg[1:0] != 2'b00);
          w_next_state   = REDIRECT;
        end else begin
          w_next_pc    = w_pc_plus4;
          ifid_write   = 1'b1;
          w_next_state = RUN;
        end
      end

      REDIRECT: begin
        if (stall) begin
          w_stall_inc  = 1'b1;
          w_next_state = STALL;
        end else begin
          w_next_pc    = w_pc_plus4;
          ifid_write   = 1'b1;
          w_next_state = RUN;
        end
      end

      default: begin
        w_next_state = BOOT;
      end
    endcase

    if (rst) begin
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  // State and PC registers. Reset takes precedence over every other input
  // and over whatever state the FSM was in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= BOOT;
      r_out_pc <= RESET_PC;
    end else begin
      r_state  <= w_next_state;
      r_out_pc <= w_next_pc;
    end
  end

  // Event counters saturate at all-ones so a long run never wraps back to a
  // small, misleading value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count    <= 16'h0000;
      r_redirect_count <= 16'h0000;
    end else begin
      if (w_stall_inc && (r_stall_count != CNT_MAX)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
      if (w_redirect_inc && (r_redirect_count != CNT_MAX)) begin
        r_redirect_count <= r_redirect_count + 16'd1;
      end
    end
  end

  // Misalignment is sticky: once a register jump with nonzero low target
  // bits is taken, the flag stays set until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else if (w_set_misalign) begin
      r_misalign <= 1'b1;
    end
  end

  assign out_pc         = r_out_pc;
  assign state          = r_state;
  assign stall_count    = r_stall_count;
  assign redirect_count = r_redirect_count;
  assign misalign       = r_misalign;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed bench for fetch_sequencer. Inputs are changed 1 time unit after a
// rising edge; registered outputs are sampled at that point, and
// combinational outputs are sampled one more time unit after the inputs
// change.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        and_z_b;
  logic [31:0] branch_adder;
  logic [1:0]  Jmp;
  logic [25:0] jmp_addr;
  logic [31:0] address_on_reg;
  logic [31:0] id_pc4;
  logic [31:0] out_pc;
  logic [31:0] pc2id;
  logic        ifid_write;
  logic        ifid_flush;
  logic [1:0]  state;
  logic [15:0] stall_count;
  logic [15:0] redirect_count;
  logic        misalign;

  int checkCount = 0;
  int passCount  = 0;

  fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .and_z_b        (and_z_b),
    .branch_adder   (branch_adder),
    .Jmp            (Jmp),
    .jmp_addr       (jmp_addr),
    .address_on_reg (address_on_reg),
    .id_pc4         (id_pc4),
    .out_pc         (out_pc),
    .pc2id          (pc2id),
    .ifid_write     (ifid_write),
    .ifid_flush     (ifid_flush),
    .state          (state),
    .stall_count    (stall_count),
    .redirect_count (redirect_count),
    .misalign       (misalign)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Return every ID-side input to its idle value.
  task automatic clearInputs();
    stall          = 1'b0;
    and_z_b        = 1'b0;
    branch_adder   = 32'h0;
    Jmp            = 2'b00;
    jmp_addr       = 26'h0;
    address_on_reg = 32'h0;
    id_pc4         = 32'h0;
  endtask

  // One reset edge, then release; the DUT is left in BOOT with out_pc=0.
  task automatic doReset();
    clearInputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Reset wins over a simultaneous stall and register jump.
  task automatic test_reset();
    rst = 1'b1;
    stall = 1'b1;
    Jmp = 2'b10;
    address_on_reg = 32'h0000_0203;
    #1;
    checkCount++; if (ifid_flush !== 1'b1) $display("[TB] FAIL reset_flush got %0b want 1", ifid_flush); else passCount++;
    checkCount++; if (ifid_write !== 1'b0) $display("[TB] FAIL reset_write got %0b want 0", ifid_write); else passCount++;
    tick();
    checkCount++; if (state !== 2'b00) $display("[TB] FAIL reset_state got %0d want 0", state); else passCount++;
    checkCount++; if (out_pc !== 32'h0) $display("[TB] FAIL reset_pc got %h want 0", out_pc); else passCount++;
    checkCount++; if (stall_count !== 16'h0 || redirect_count !== 16'h0) $display("[TB] FAIL reset_counts got %h/%h want 0/0", stall_count, redirect_count); else passCount++;
    checkCount++; if (misalign !== 1'b0) $display("[TB] FAIL reset_misalign got %0b want 0", misalign); else passCount++;
    rst = 1'b0;
    clearInputs();
  endtask

  // BOOT for one cycle, then sequential fetch 0,4,8,12.
  task automatic test_sequential();
    doReset();
    checkCount++; if (state !== 2'b00 || ifid_flush !== 1'b1 || ifid_write !== 1'b0) $display("[TB] FAIL boot_ctrl got st=%0d fl=%0b wr=%0b want 0/1/0", state, ifid_flush, ifid_write); else passCount++;
    tick();
    checkCount++; if (state !== 2'b01 || out_pc !== 32'h0) $display("[TB] FAIL boot_exit got st=%0d pc=%h want 1/0", state, out_pc); else passCount++;
    checkCount++; if (ifid_flush !== 1'b0 || ifid_write !== 1'b1) $display("[TB] FAIL run_ctrl got fl=%0b wr=%0b want 0/1", ifid_flush, ifid_write); else passCount++;
    checkCount++; if (pc2id !== 32'h4) $display("[TB] FAIL pc2id got %h want 4", pc2id); else passCount++;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkCount++; if (out_pc !== 32'(4 * i) || ifid_flush !== 1'b0) $display("[TB] FAIL seq_pc%0d got %h fl=%0b want %h fl=0", i, out_pc, ifid_flush, 32'(4 * i)); else passCount++;
    end
  endtask

  // Three-cycle load-use stall at 0x40.
  task automatic test_stall();
    doReset();
    tick();
    repeat (16) tick();
    checkCount++; if (out_pc !== 32'h40) $display("[TB] FAIL stall_pre_pc got %h want 40", out_pc); else passCount++;
    stall = 1'b1;
    #1;
    checkCount++; if (ifid_write !== 1'b0 || ifid_flush !== 1'b0) $display("[TB] FAIL stall_ctrl got wr=%0b fl=%0b want 0/0", ifid_write, ifid_flush); else passCount++;
    repeat (3) tick();
    checkCount++; if (out_pc !== 32'h40) $display("[TB] FAIL stall_hold_pc got %h want 40", out_pc); else passCount++;
    checkCount++; if (stall_count !== 16'd3) $display("[TB] FAIL stall_count got %0d want 3", stall_count); else passCount++;
    checkCount++; if (state !== 2'b10 || ifid_write !== 1'b0) $display("[TB] FAIL stall_state got st=%0d wr=%0b want 2/0", state, ifid_write); else passCount++;
    stall = 1'b0;
    tick();
    checkCount++; if (out_pc !== 32'h44 || state !== 2'b01) $display("[TB] FAIL stall_release got pc=%h st=%0d want 44/1", out_pc, state); else passCount++;
  endtask

  // Taken branch, then a stale branch seen in REDIRECT is ignored.
  task automatic test_branch();
    doReset();
    tick();
    and_z_b = 1'b1;
    branch_adder = 32'h0000_0100;
    #1;
    checkCount++; if (ifid_flush !== 1'b1 || ifid_write !== 1'b1) $display("[TB] FAIL br_ctrl got fl=%0b wr=%0b want 1/1", ifid_flush, ifid_write); else passCount++;
    tick();
    checkCount++; if (out_pc !== 32'h100 || state !== 2'b11) $display("[TB] FAIL br_target got pc=%h st=%0d want 100/3", out_pc, state); else passCount++;
    checkCount++; if (redirect_count !== 16'd1) $display("[TB] FAIL br_count got %0d want 1", redirect_count); else passCount++;
    checkCount++; if (ifid_flush !== 1'b0) $display("[TB] FAIL br_redir_flush got %0b want 0", ifid_flush); else passCount++;
    tick();
    checkCount++; if (out_pc !== 32'h104 || state !== 2'b01 || redirect_count !== 16'd1) $display("[TB] FAIL br_ignore got pc=%h st=%0d cnt=%0d want 104/1/1", out_pc, state, redirect_count); else passCount++;
    and_z_b = 1'b0;
  endtask

  // Immediate jump, register jump with misaligned target, and Jmp=11.
  task automatic test_jump();
    doReset();
    tick();
    Jmp = 2'b01;
    id_pc4 = 32'h9000_0010;
    jmp_addr = 26'h10;
    tick();
    checkCount++; if (out_pc !== 32'h9000_0040) $display("[TB] FAIL jimm_pc got %h want 90000040", out_pc); else passCount++;
    checkCount++; if (misalign !== 1'b0) $display("[TB] FAIL jimm_misalign got %0b want 0", misalign); else passCount++;
    Jmp = 2'b00;
    tick();
    checkCount++; if (out_pc !== 32'h9000_0044) $display("[TB] FAIL jimm_after got %h want 90000044", out_pc); else passCount++;
    Jmp = 2'b10;
    address_on_reg = 32'h0000_0203;
    tick();
    checkCount++; if (out_pc !== 32'h200 || misalign !== 1'b1) $display("[TB] FAIL jreg_pc got pc=%h mis=%0b want 200/1", out_pc, misalign); else passCount++;
    checkCount++; if (redirect_count !== 16'd2) $display("[TB] FAIL jreg_count got %0d want 2", redirect_count); else passCount++;
    Jmp = 2'b00;
    repeat (3) tick();
    checkCount++; if (out_pc !== 32'h20C || misalign !== 1'b1) $display("[TB] FAIL misalign_sticky got pc=%h mis=%0b want 20c/1", out_pc, misalign); else passCount++;
    Jmp = 2'b11;
    #1;
    checkCount++; if (ifid_flush !== 1'b0) $display("[TB] FAIL j11_flush got %0b want 0", ifid_flush); else passCount++;
    tick();
    checkCount++; if (out_pc !== 32'h210 || state !== 2'b01) $display("[TB] FAIL j11_pc got pc=%h st=%0d want 210/1", out_pc, state); else passCount++;
    and_z_b = 1'b1;
    branch_adder = 32'h0000_0800;
    tick();
    checkCount++; if (out_pc !== 32'h800) $display("[TB] FAIL j11_branch got %h want 800", out_pc); else passCount++;
    clearInputs();
  endtask

  // Stall coincident with a register jump holds; the jump is taken after.
  task automatic test_stall_redirect();
    doReset();
    tick();
    stall = 1'b1;
    Jmp = 2'b10;
    address_on_reg = 32'h0000_0300;
    #1;
    checkCount++; if (ifid_flush !== 1'b0 || ifid_write !== 1'b0) $display("[TB] FAIL sr_hold_ctrl got fl=%0b wr=%0b want 0/0", ifid_flush, ifid_write); else passCount++;
    tick();
    checkCount++; if (out_pc !== 32'h0 || state !== 2'b10 || redirect_count !== 16'd0) $display("[TB] FAIL sr_hold got pc=%h st=%0d rc=%0d want 0/2/0", out_pc, state, redirect_count); else passCount++;
    stall = 1'b0;
    #1;
    checkCount++; if (ifid_flush !== 1'b1) $display("[TB] FAIL sr_flush got %0b want 1", ifid_flush); else passCount++;
    tick();
    checkCount++; if (out_pc !== 32'h300 || state !== 2'b11 || redirect_count !== 16'd1) $display("[TB] FAIL sr_taken got pc=%h st=%0d rc=%0d want 300/3/1", out_pc, state, redirect_count); else passCount++;
    checkCount++; if (misalign !== 1'b0) $display("[TB] FAIL sr_misalign got %0b want 0", misalign); else passCount++;
    clearInputs();
  endtask

  // PC+4 wraps from the top of the address space to zero.
  task automatic test_wrap();
    doReset();
    tick();
    Jmp = 2'b10;
    address_on_reg = 32'hFFFF_FFFC;
    tick();
    checkCount++; if (out_pc !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_pre got %h want fffffffc", out_pc); else passCount++;
    Jmp = 2'b00;
    #1;
    checkCount++; if (pc2id !== 32'h0) $display("[TB] FAIL wrap_pc2id got %h want 0", pc2id); else passCount++;
    tick();
    checkCount++; if (out_pc !== 32'h0 || state !== 2'b01) $display("[TB] FAIL wrap_pc got pc=%h st=%0d want 0/1", out_pc, state); else passCount++;
    clearInputs();
  endtask

  // Long stall saturates the counter; reset from STALL clears everything.
  task automatic test_saturate_reset();
    doReset();
    tick();
    stall = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    checkCount++; if (stall_count !== 16'hFFFF) $display("[TB] FAIL sat_count got %h want ffff", stall_count); else passCount++;
    checkCount++; if (state !== 2'b10 || out_pc !== 32'h0) $display("[TB] FAIL sat_hold got st=%0d pc=%h want 2/0", state, out_pc); else passCount++;
    tick();
    checkCount++; if (stall_count !== 16'hFFFF) $display("[TB] FAIL sat_stay got %h want ffff", stall_count); else passCount++;
    rst = 1'b1;
    #1;
    checkCount++; if (ifid_flush !== 1'b1 || ifid_write !== 1'b0) $display("[TB] FAIL rst_stall_ctrl got fl=%0b wr=%0b want 1/0", ifid_flush, ifid_write); else passCount++;
    tick();
    checkCount++; if (state !== 2'b00 || stall_count !== 16'h0 || redirect_count !== 16'h0 || out_pc !== 32'h0) $display("[TB] FAIL rst_stall got st=%0d sc=%h rc=%h pc=%h want 0/0/0/0", state, stall_count, redirect_count, out_pc); else passCount++;
    rst = 1'b0;
    clearInputs();
  endtask

  initial begin
    clearInputs();
    rst = 1'b1;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jump();
    test_stall_redirect();
    test_wrap();
    test_saturate_reset();
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
